bus_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the shared broadcast bus connecting `DRVRS` device FIFOs of `BITS`-bit packets. It grants the bus to one device with a pending packet and pops that packet from the device's FIFO head. It then decodes the destination ID in the packet's upper byte and pushes the packet to the addressed device, or to every device except the source on broadcast. It sits between the per-device FIFOs and the bus wiring, and it is the block the agent/driver and checker environment exercise.

---
 rtl/bus_arb_pkg.sv | 15 +
 rtl/bus_rr_arbiter_if.sv | 25 ++
 rtl/rr_pick.sv | 30 +++
 rtl/bus_rr_arbiter.sv | 103 ++++++++++
 tb/tb_bus_rr_arbiter.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the round-robin bus arbiter slice.
package bus_arb_pkg;

    typedef enum logic {IDLE, XFER} arb_state_t;

    localparam int unsigned ID_W      = 8;
    localparam int unsigned PKT_MAX_W = 64;

    // Packets are passed zero-extended to PKT_MAX_W; bits gives the real width.
    function automatic logic [ID_W-1:0] dest_id(input logic [PKT_MAX_W-1:0] pkt,
                                                input int unsigned           bits);
        return ID_W'(pkt >> (bits - ID_W));
    endfunction

endpackage

// File: rtl/bus_rr_arbiter_if.sv
// Device-FIFO / bus signal bundle seen by the arbiter (master) and the FIFO side (slave).
interface bus_rr_arbiter_if #(
    parameter int unsigned BITS  = 16,
    parameter int unsigned DRVRS = 4
);

    logic [DRVRS-1:0]           pndng;
    logic [DRVRS-1:0][BITS-1:0] D_pop;
    logic [DRVRS-1:0]           pop;
    logic [DRVRS-1:0]           push;
    logic [BITS-1:0]            D_push;
    logic                       drop;
    logic                       busy;

    modport master (
        input  pndng, D_pop,
        output pop, push, D_push, drop, busy
    );

    modport slave (
        output pndng, D_pop,
        input  pop, push, D_push, drop, busy
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit scanning upward from last+1, wrapping.
module rr_pick #(
    parameter int unsigned DRVRS = 4,
    parameter int unsigned SW    = $clog2(DRVRS)
) (
    input  logic [DRVRS-1:0] req,
    input  logic [SW-1:0]    last,
    output logic [DRVRS-1:0] gnt,
    output logic [SW-1:0]    sel
);

    logic [SW-1:0] idx;
    logic          found;

    always_comb begin
        gnt   = '0;
        sel   = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 1; k <= DRVRS; k++) begin
            idx = SW'((32'(last) + k) % DRVRS);
            if (!found && req[idx]) begin
                found    = 1'b1;
                sel      = idx;
                gnt[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin bus arbiter/sequencer: pop one packet, then push it to its destination(s).
// Optional BUS_ARB_STATS_EN adds saturating grant/drop counters.
module bus_rr_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned     BITS      = 16,
    parameter int unsigned     DRVRS     = 4,
    parameter logic [ID_W-1:0] BROADCAST = 8'hFF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    bus_rr_arbiter_if.master       bus
`ifdef BUS_ARB_STATS_EN
    ,
    output logic [DRVRS-1:0][15:0] grant_cnt,
    output logic [15:0]            drop_cnt
`endif
);

    localparam int unsigned SW = $clog2(DRVRS);

    arb_state_t       state_q, state_d;
    logic [SW-1:0]    last_q, src_q, sel;
    logic [DRVRS-1:0] gnt;
    logic [BITS-1:0]  data_q;
    logic [ID_W-1:0]  id;
    logic             grant;

    rr_pick #(
        .DRVRS (DRVRS),
        .SW    (SW)
    ) u_pick (
        .req  (bus.pndng),
        .last (last_q),
        .gnt  (gnt),
        .sel  (sel)
    );

    // pop is combinational from pndng, so it is gated by rst_n to stay low during reset.
    assign grant = rst_n && (state_q == IDLE) && (|bus.pndng);
    assign id    = dest_id(PKT_MAX_W'(data_q), BITS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= SW'(DRVRS - 1);
            src_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                data_q <= bus.D_pop[sel];
                src_q  <= sel;
                last_q <= sel;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        bus.pop  = '0;
        bus.push = '0;
        bus.drop = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    bus.pop = gnt;
                    state_d = XFER;
                end
            end
            XFER: begin
                state_d = IDLE;
                if (id == BROADCAST)
                    bus.push = ~(DRVRS'(1) << src_q);
                else if ((id < ID_W'(DRVRS)) && (id != ID_W'(src_q)))
                    bus.push = DRVRS'(1) << id;
                else
                    bus.drop = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.D_push = data_q;
    assign bus.busy   = (state_q == XFER);

`ifdef BUS_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            for (int unsigned i = 0; i < DRVRS; i++) begin
                if (bus.pop[i] && (grant_cnt[i] != 16'hFFFF))
                    grant_cnt[i] <= grant_cnt[i] + 16'd1;
            end
            if (bus.drop && (drop_cnt != 16'hFFFF))
                drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Self-checking bench for bus_rr_arbiter: vector table, hand sequences and a grant/push scoreboard.
module tb_bus_rr_arbiter;

    localparam int unsigned BITS  = 16;
    localparam int unsigned DRVRS = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    bus_rr_arbiter_if #(.BITS(BITS), .DRVRS(DRVRS)) bif ();

`ifdef BUS_ARB_STATS_EN
    logic [DRVRS-1:0][15:0] grant_cnt;
    logic [15:0]            drop_cnt;
`endif

    bus_rr_arbiter #(
        .BITS      (BITS),
        .DRVRS     (DRVRS),
        .BROADCAST (8'hFF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
`ifdef BUS_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt),
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic at_drive();
        @(posedge clk);
        #1;
    endtask

    // Reference decode of a popped packet from device s.
    function automatic void model(input logic [15:0] d, input int unsigned s,
                                  output logic [3:0] p, output logic dr);
        logic [7:0] id;
        id = d[15:8];
        p  = '0;
        dr = 1'b0;
        if (id == 8'hFF)
            p = 4'hF & ~(4'b0001 << s);
        else if ((id < 8'd4) && (32'(id) != s))
            p = 4'b0001 << id;
        else
            dr = 1'b1;
    endfunction

    typedef struct {
        logic [3:0]  push;
        logic        drop;
        logic [15:0] data;
    } exp_t;

    exp_t        sb[$];
    int unsigned m_last = 3;

    // Scoreboard: each observed grant pushes its expected bus result for the next cycle.
    always @(negedge clk) begin : monitor
        exp_t        e;
        int unsigned s;
        logic        found;
        if (!rst_n) begin
            sb.delete();
            m_last = 3;
        end else if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("sb_push", 32'(bif.push), 32'(e.push));
            chk("sb_drop", 32'(bif.drop), 32'(e.drop));
            chk("sb_dpush", 32'(bif.D_push), 32'(e.data));
            chk("sb_xfer_busy_nopop", 32'({bif.busy, bif.pop}), 32'h10);
        end else begin
            chk("sb_idle_quiet", 32'({bif.busy, bif.push, bif.drop}), 32'h0);
            if (bif.pndng != '0) begin
                found = 1'b0;
                s     = m_last;
                for (int unsigned k = 1; k <= 4; k++) begin
                    if (!found && bif.pndng[(m_last + k) % 4]) begin
                        found = 1'b1;
                        s     = (m_last + k) % 4;
                    end
                end
                chk("sb_pop", 32'(bif.pop), 32'(4'b0001 << s));
                e.data = bif.D_pop[s];
                model(e.data, s, e.push, e.drop);
                sb.push_back(e);
                m_last = s;
            end else begin
                chk("sb_nopop", 32'(bif.pop), 32'h0);
            end
        end
    end

    typedef struct {
        logic [3:0]  pndng;
        int unsigned dev;
        logic [15:0] data;
        logic [3:0]  exp_pop;
        logic [3:0]  exp_push;
        logic        exp_drop;
    } vec_t;

    vec_t        vecs[9];
    int unsigned exp_grant[4];
    int unsigned exp_drops;

    initial begin
        vecs[0] = '{4'b0001, 0, 16'h02AB, 4'b0001, 4'b0100, 1'b0};
        vecs[1] = '{4'b0100, 2, 16'hFF55, 4'b0100, 4'b1011, 1'b0};
        vecs[2] = '{4'b0010, 1, 16'h0111, 4'b0010, 4'b0000, 1'b1};
        vecs[3] = '{4'b0010, 1, 16'h0722, 4'b0010, 4'b0000, 1'b1};
        vecs[4] = '{4'b1000, 3, 16'h0000, 4'b1000, 4'b0001, 1'b0};
        vecs[5] = '{4'b1000, 3, 16'h03C3, 4'b1000, 4'b0000, 1'b1};
        vecs[6] = '{4'b0001, 0, 16'hFF00, 4'b0001, 4'b1110, 1'b0};
        vecs[7] = '{4'b0100, 2, 16'hFE12, 4'b0100, 4'b0000, 1'b1};
        vecs[8] = '{4'b0010, 1, 16'h0209, 4'b0010, 4'b0100, 1'b0};
        exp_grant = '{0, 0, 0, 0};
        exp_drops = 0;

        bif.pndng = '0;
        bif.D_pop = '0;
        #1;
        chk("rst_pop", 32'(bif.pop), 32'h0);
        chk("rst_push", 32'(bif.push), 32'h0);
        chk("rst_dpush", 32'(bif.D_push), 32'h0);
        chk("rst_drop", 32'(bif.drop), 32'h0);
        chk("rst_busy", 32'(bif.busy), 32'h0);
`ifdef BUS_ARB_STATS_EN
        chk("rst_drop_cnt", 32'(drop_cnt), 32'h0);
        chk("rst_grant_cnt", 32'(grant_cnt), 32'h0);
`endif
        at_drive();
        at_drive();
        rst_n = 1'b1;

        // All devices pending, each addressing its successor.
        for (int unsigned i = 0; i < 4; i++)
            bif.D_pop[i] = {8'((i + 1) % 4), 8'(8'h10 + i)};
        bif.pndng = 4'b1111;
        for (int unsigned k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k % 2 == 0) begin
                chk("rr_pop", 32'(bif.pop), 32'(4'b0001 << ((k / 2) % 4)));
                exp_grant[(k / 2) % 4]++;
            end else begin
                chk("rr_push", 32'(bif.push), 32'(4'b0001 << ((k / 2 + 1) % 4)));
                chk("rr_nodrop", 32'(bif.drop), 32'h0);
            end
        end
        at_drive();
        bif.pndng = '0;

        // Single-packet vectors.
        for (int unsigned i = 0; i < 9; i++) begin
            at_drive();
            bif.pndng             = vecs[i].pndng;
            bif.D_pop[vecs[i].dev] = vecs[i].data;
            @(negedge clk);
            chk("vec_pop", 32'(bif.pop), 32'(vecs[i].exp_pop));
            chk("vec_pop_nopush", 32'(bif.push), 32'h0);
            at_drive();
            bif.pndng = '0;
            @(negedge clk);
            chk("vec_push", 32'(bif.push), 32'(vecs[i].exp_push));
            chk("vec_drop", 32'(bif.drop), 32'(vecs[i].exp_drop));
            chk("vec_dpush", 32'(bif.D_push), 32'(vecs[i].data));
            chk("vec_busy", 32'(bif.busy), 32'h1);
            exp_grant[vecs[i].dev]++;
            if (vecs[i].exp_drop) exp_drops++;
        end
        at_drive();
        @(negedge clk);
        chk("idle_busy", 32'(bif.busy), 32'h0);
`ifdef BUS_ARB_STATS_EN
        chk("stat_drop_cnt", 32'(drop_cnt), 32'(exp_drops));
        for (int unsigned i = 0; i < 4; i++)
            chk("stat_grant_cnt", 32'(grant_cnt[i]), 32'(exp_grant[i]));
`endif

        // Reset in the middle of a transfer; last must return to DRVRS-1.
        at_drive();
        bif.D_pop[0] = 16'h0155;
        bif.D_pop[1] = 16'h0033;
        bif.pndng    = 4'b0001;
        @(negedge clk);
        chk("mid_pop", 32'(bif.pop), 32'h1);
        at_drive();
        bif.pndng = '0;
        chk("mid_busy", 32'(bif.busy), 32'h1);
        chk("mid_push", 32'(bif.push), 32'h2);
        rst_n = 1'b0;
        #1;
        chk("arst_push", 32'(bif.push), 32'h0);
        chk("arst_dpush", 32'(bif.D_push), 32'h0);
        chk("arst_busy", 32'(bif.busy), 32'h0);
        chk("arst_drop", 32'(bif.drop), 32'h0);
        bif.pndng = 4'b0011;
        at_drive();
        at_drive();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_grant", 32'(bif.pop), 32'h1);
        at_drive();
        bif.pndng = '0;
        @(negedge clk);
        chk("post_rst_push", 32'(bif.push), 32'h2);
        at_drive();
        at_drive();
        at_drive();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
